// File: rtl/dsdmnist_pkg.sv
// Shared types and constants for the dsdmnist fully-connected datapath.
// Holds the sequencer state encoding, the issue-tag layout and the result-tag width.
package dsdmnist_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RESULT, DONE} seq_state_t;

  typedef struct packed {
    logic first;
    logic vld;
  } tag_t;

  function automatic int grp_w(input int n_grp);
    return (n_grp > 1) ? $clog2(n_grp) : 1;
  endfunction

endpackage

// File: rtl/dsdmnist_fc_sequencer_if.sv
// Sequencer-side bundle: start/status, memory read port, MAC lane control and result port.
// The result port is valid/ready; all other signals are unconditioned strobes or levels.
interface dsdmnist_fc_sequencer_if #(
  parameter int NLANE = 2,
  parameter int AW    = 16,
  parameter int GW    = 1
) ();

  logic                                start;
  logic                                busy;
  logic                                done;
  logic                                rd_en;
  logic [AW-1:0]                       act_addr;
  logic [AW-1:0]                       wgt_addr;
  logic                                mac_rst;
  logic                                mac_acc_en;
  logic [NLANE*dsdmnist_pkg::ACC_W-1:0] mac_acc;
  logic                                res_valid;
  logic                                res_ready;
  logic [NLANE*dsdmnist_pkg::ACC_W-1:0] res_data;
  logic [GW-1:0]                       res_grp;

  modport master (
    input  start, mac_acc, res_ready,
    output busy, done, rd_en, act_addr, wgt_addr, mac_rst, mac_acc_en,
           res_valid, res_data, res_grp
  );

  modport slave (
    output start, mac_acc, res_ready,
    input  busy, done, rd_en, act_addr, wgt_addr, mac_rst, mac_acc_en,
           res_valid, res_data, res_grp
  );

endinterface

// File: rtl/dsdmnist_tag_pipe.sv
// Clearable shift register: stage i holds the word entered i+1 cycles earlier.
// Latency DEPTH cycles end to end; no backpressure, shifts every cycle.
module dsdmnist_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              din,
  output logic [DEPTH-1:0][W-1:0]   stages
);

  logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign stages = pipe_q;

endmodule

// File: rtl/dsdmnist_fc_sequencer.sv
// Drives NLANE MAC lanes through N_GRP dot products of N_IN terms; first result valid N_IN+RDLAT+2
// cycles after a group's first read. Reads stop while a result waits for ready.
module dsdmnist_fc_sequencer
  import dsdmnist_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_GRP = 5,
  parameter int NLANE = 2,
  parameter int RDLAT = 1,
  parameter int AW    = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTn,
  dsdmnist_fc_sequencer_if.master bus
);

  localparam int              GW       = grp_w(N_GRP);
  localparam int              DEPTH    = RDLAT + 2;
  localparam logic [AW-1:0]   K_LAST   = AW'(N_IN - 1);
  localparam logic [GW-1:0]   GRP_LAST = GW'(N_GRP - 1);

  seq_state_t                 state_q, state_d;
  logic [AW-1:0]              k_q, k_d;
  logic [AW-1:0]              wgt_q, wgt_d;
  logic [GW-1:0]              grp_q, grp_d;
  logic [NLANE*ACC_W-1:0]     res_data_q, res_data_d;
  tag_t                       tag_in;
  logic [DEPTH-1:0][1:0]      tags;
  logic                       live;
  logic                       rd_en;

  dsdmnist_tag_pipe #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_tag_pipe (
    .clk    (i_CLK),
    .rst_n  (i_RSTn),
    .din    (tag_in),
    .stages (tags)
  );

  // Tags below the top stage still have an ACC_EN ahead of them; once only the top
  // stage holds the group's last tag, the accumulators are final this cycle.
  always_comb begin
    live = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      live = live | tags[i][0];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wgt_d      = wgt_q;
    grp_d      = grp_q;
    res_data_d = res_data_q;
    tag_in     = '0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          k_d     = '0;
          wgt_d   = '0;
          grp_d   = '0;
        end
      end
      ISSUE: begin
        rd_en        = 1'b1;
        tag_in.vld   = 1'b1;
        tag_in.first = (k_q == '0);
        wgt_d        = wgt_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (tags[DEPTH-1][0] && !live) begin
          state_d    = RESULT;
          res_data_d = bus.mac_acc;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          if (grp_q == GRP_LAST) begin
            state_d = DONE;
          end else begin
            grp_d   = grp_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_q    <= IDLE;
      k_q        <= '0;
      wgt_q      <= '0;
      grp_q      <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wgt_q      <= wgt_d;
      grp_q      <= grp_d;
      res_data_q <= res_data_d;
    end
  end

  // MAC_RST lands as the first product is registered; ACC_EN one cycle later adds it.
  assign bus.mac_rst    = tags[RDLAT-1][1] & tags[RDLAT-1][0];
  assign bus.mac_acc_en = tags[RDLAT][0];
  assign bus.rd_en      = rd_en;
  assign bus.act_addr   = k_q;
  assign bus.wgt_addr   = wgt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.res_valid  = (state_q == RESULT);
  assign bus.res_data   = res_data_q;
  assign bus.res_grp    = grp_q;

endmodule

// File: tb/tb_dsdmnist_fc_sequencer.sv
// Three sequencers (RDLAT=1,2,3) with BRAM and MAC-lane models; expected dot products are
// queued at START and compared by a per-instance monitor at every result handshake.
module tb_dsdmnist_fc_sequencer;

  localparam int N_IN  = 4;
  localparam int N_GRP = 2;

  typedef struct {
    logic [63:0] data;
    int          grp;
  } res_t;

  logic       clk;
  logic [2:0] start_v, ready_v, rst_n_v, valid_v, zero_v;
  byte        act_mem [N_IN];
  byte        wgt_mem [N_IN*N_GRP][2];
  res_t       exp_q [3][$];
  int         n_cmp;
  int         n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int RL = d + 1;

    dsdmnist_fc_sequencer_if #(.NLANE(2), .AW(16), .GW(1)) bus ();

    dsdmnist_fc_sequencer #(
      .N_IN(N_IN), .N_GRP(N_GRP), .NLANE(2), .RDLAT(RL), .AW(16)
    ) dut (
      .i_CLK  (clk),
      .i_RSTn (rst_n_v[d]),
      .bus    (bus.master)
    );

    byte act_p [RL];
    byte w0_p  [RL];
    byte w1_p  [RL];
    int  prod0, prod1, acc0, acc1;

    always @(posedge clk) begin
      if (bus.rd_en) begin
        act_p[0] <= act_mem[bus.act_addr[1:0]];
        w0_p[0]  <= wgt_mem[bus.wgt_addr[2:0]][0];
        w1_p[0]  <= wgt_mem[bus.wgt_addr[2:0]][1];
      end
      for (int i = 1; i < RL; i++) begin
        act_p[i] <= act_p[i-1];
        w0_p[i]  <= w0_p[i-1];
        w1_p[i]  <= w1_p[i-1];
      end
      prod0 <= int'(act_p[RL-1]) * int'(w0_p[RL-1]);
      prod1 <= int'(act_p[RL-1]) * int'(w1_p[RL-1]);
      if (bus.mac_rst) begin
        acc0 <= 0;
        acc1 <= 0;
      end else if (bus.mac_acc_en) begin
        acc0 <= acc0 + prod0;
        acc1 <= acc1 + prod1;
      end
    end

    assign bus.mac_acc   = {acc1, acc0};
    assign bus.start     = start_v[d];
    assign bus.res_ready = ready_v[d];
    assign valid_v[d]    = bus.res_valid;
    assign zero_v[d]     = !(bus.busy | bus.done | bus.rd_en | bus.mac_rst | bus.mac_acc_en | bus.res_valid)
                           && bus.act_addr == 0 && bus.wgt_addr == 0 && bus.res_data == 0 && bus.res_grp == 0;

    int          cyc = 0, first_rd = 0, rd_cnt = 0;
    bit          p_busy, p_rd, p_vld, p_rdy, exp_issue, exp_done, exp_idle;
    logic [63:0] p_data;
    logic        p_grp;
    res_t        r;

    always @(negedge clk) begin
      cyc++;
      if (!rst_n_v[d]) begin
        p_busy = 0; p_rd = 0; p_vld = 0; p_rdy = 0;
        exp_issue = 0; exp_done = 0; exp_idle = 0;
      end else begin
        if (bus.busy && !p_busy) rd_cnt = 0;
        if (p_vld && !p_rdy)
          check(bus.res_valid && !bus.rd_en && bus.res_data == p_data && bus.res_grp == p_grp,
                $sformatf("stall_hold[rl%0d]", RL), bus.res_data, p_data);
        if (exp_issue)
          check(bus.rd_en && !bus.res_valid, $sformatf("issue_after_hs[rl%0d]", RL), 64'(bus.rd_en), 64'd1);
        if (bus.done || exp_done)
          check(bus.done == exp_done && bus.busy, $sformatf("done_pulse[rl%0d]", RL),
                64'({bus.done, bus.busy}), 64'({exp_done, 1'b1}));
        if (exp_idle)
          check(!bus.busy && !bus.rd_en && !bus.done, $sformatf("idle_after_done[rl%0d]", RL),
                64'(bus.busy), 64'd0);
        if (bus.rd_en) begin
          if (!p_rd) first_rd = cyc;
          check(bus.act_addr == 16'(rd_cnt % N_IN) && bus.wgt_addr == 16'(rd_cnt),
                $sformatf("rd_addr[rl%0d]", RL), {bus.act_addr, bus.wgt_addr},
                {16'(rd_cnt % N_IN), 16'(rd_cnt)});
          rd_cnt++;
        end
        if (bus.res_valid && !p_vld)
          check(cyc - first_rd == N_IN + RL + 2, $sformatf("first_valid_lat[rl%0d]", RL),
                64'(cyc - first_rd), 64'(N_IN + RL + 2));
        exp_issue = 0;
        exp_done  = 0;
        exp_idle  = bus.done;
        if (bus.res_valid && bus.res_ready) begin
          check(exp_q[d].size() != 0, $sformatf("unexpected_result[rl%0d]", RL), 64'(exp_q[d].size()), 64'd1);
          if (exp_q[d].size() != 0) begin
            r = exp_q[d].pop_front();
            check(bus.res_data == r.data, $sformatf("res_data[rl%0d]", RL), bus.res_data, r.data);
            check(int'(bus.res_grp) == r.grp, $sformatf("res_grp[rl%0d]", RL), 64'(bus.res_grp), 64'(r.grp));
            exp_issue = (r.grp != N_GRP - 1);
            exp_done  = (r.grp == N_GRP - 1);
          end
        end
        p_busy = bus.busy;
        p_rd   = bus.rd_en;
        p_vld  = bus.res_valid;
        p_rdy  = bus.res_ready;
        p_data = bus.res_data;
        p_grp  = bus.res_grp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dot(input int g, input int n);
    int s = 0;
    for (int k = 0; k < N_IN; k++) s += int'(act_mem[k]) * int'(wgt_mem[g*N_IN + k][n]);
    return s;
  endfunction

  task automatic randomize_mem();
    for (int k = 0; k < N_IN; k++) act_mem[k] = byte'($urandom);
    for (int a = 0; a < N_IN*N_GRP; a++) begin
      wgt_mem[a][0] = byte'($urandom);
      wgt_mem[a][1] = byte'($urandom);
    end
  endtask

  task automatic push_expect(input int d);
    res_t e;
    for (int g = 0; g < N_GRP; g++) begin
      e.data = {32'(dot(g, 1)), 32'(dot(g, 0))};
      e.grp  = g;
      exp_q[d].push_back(e);
    end
  endtask

  // chain: called in the DONE cycle of the previous run; START is held over DONE and the next IDLE cycle.
  task automatic run_layer(input int d, input bit chain, input bit stall, input bit spur, input bit rst_mid);
    int w;
    if (!chain) repeat (2) tick();
    push_expect(d);
    start_v[d] = 1'b1;
    tick();
    if (chain) tick();
    start_v[d] = 1'b0;
    if (rst_mid) begin
      repeat (N_IN) tick();
      rst_n_v[d] = 1'b0;
      tick();
      check(zero_v[d], $sformatf("mid_drain_reset_outputs[%0d]", d), 64'(zero_v[d]), 64'd1);
      rst_n_v[d] = 1'b1;
      exp_q[d].delete();
      repeat (12) tick();
      return;
    end
    if (spur) begin
      tick();
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
    end
    for (int g = 0; g < N_GRP; g++) begin
      w = 0;
      while (!valid_v[d] && w < 100) begin
        tick();
        w++;
      end
      check(valid_v[d], $sformatf("valid_timeout[%0d]", d), 64'(valid_v[d]), 64'd1);
      if (!valid_v[d]) begin
        rst_n_v[d] = 1'b0;
        tick();
        rst_n_v[d] = 1'b1;
        exp_q[d].delete();
        return;
      end
      if (stall && g == 0) repeat (5) tick();
      else repeat ($urandom_range(0, 2)) tick();
      ready_v[d] = 1'b1;
      tick();
      ready_v[d] = 1'b0;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    start_v = '0;
    ready_v = '0;
    rst_n_v = '0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++)
      check(zero_v[d], $sformatf("reset_state[%0d]", d), 64'(zero_v[d]), 64'd1);
    rst_n_v = '1;
    tick();

    for (int d = 0; d < 3; d++) begin
      randomize_mem();
      for (int k = 0; k < N_IN; k++) begin
        act_mem[k]    = byte'(k + 1);
        wgt_mem[k][0] = 8'sd1;
        wgt_mem[k][1] = 8'sd2;
      end
      run_layer(d, 0, 1, 0, 0);

      randomize_mem();
      for (int k = 0; k < N_IN; k++) begin
        act_mem[k]           = -8'sd128;
        wgt_mem[N_IN + k][0] = -8'sd128;
      end
      wgt_mem[N_IN + 0][1] = 8'sd127;
      wgt_mem[N_IN + 1][1] = -8'sd128;
      wgt_mem[N_IN + 2][1] = 8'sd0;
      wgt_mem[N_IN + 3][1] = 8'sd1;
      run_layer(d, 0, 0, 1, 0);

      for (int i = 0; i < 4; i++) begin
        randomize_mem();
        run_layer(d, 1, 0, 0, 0);
      end

      randomize_mem();
      run_layer(d, 0, 0, 0, 1);
      randomize_mem();
      run_layer(d, 0, 0, 0, 0);

      repeat (5) tick();
      check(exp_q[d].size() == 0, $sformatf("scoreboard_drained[%0d]", d), 64'(exp_q[d].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
